garbage_insert: RTL and testbench

GARBAGE_INSERT -- requirements
Module: garbage_insert

---
 rtl/garbage_insert.sv | 113 +++++++++++
 tb/tb_garbage_insert.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/garbage_insert.sv
// Inserts up to MAX_LINES garbage rows at the bottom of a board and pushes the
// existing rows upward, one row per clock. Rows that fall off the top raise topout.
module garbage_insert #(
    parameter int unsigned BOARD_W      = 10,
    parameter int unsigned BOARD_H      = 20,
    parameter int unsigned BRICK_LEN    = 3,
    parameter int unsigned BOARD_SIZE   = BOARD_H * BOARD_W * (BRICK_LEN + 1),
    parameter logic [BRICK_LEN-1:0] GARBAGE_TYPE = 7,
    parameter int unsigned MAX_LINES    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            num_lines,
    input  logic [3:0]            hole_col,
    input  logic [BOARD_SIZE-1:0] cur_board,
    output logic                  busy,
    output logic                  done,
    output logic                  topout,
    output logic [BOARD_SIZE-1:0] nxt_board
);

    localparam int unsigned ROW_T     = BOARD_W * BRICK_LEN;
    localparam int unsigned TYPE_BITS = BOARD_H * ROW_T;
    localparam int unsigned FILL_BITS = BOARD_H * BOARD_W;
    localparam logic [BOARD_SIZE-1:0] EMPTY_BOARD = {{FILL_BITS{1'b0}}, {TYPE_BITS{1'b1}}};
    localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);

    typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

    state_t                  state;
    logic [4:0]              ctr;
    logic [2:0]              n_lat;
    logic [3:0]              h_lat;
    logic [BOARD_SIZE-1:0]   lat_board;

    logic [BOARD_W-1:0]      garb_fill;
    logic [ROW_T-1:0]        garb_type;
    logic                    is_garb;
    logic [4:0]              src_row;
    logic [BOARD_W-1:0]      row_fill;
    logic [ROW_T-1:0]        row_type;
    logic                    drop_hit;

    always_comb begin
        garb_fill        = '1;
        garb_fill[h_lat] = 1'b0;
        garb_type        = '1;
        for (int unsigned c = 0; c < BOARD_W; c++) begin
            if (c != int'(h_lat))
                garb_type[c*BRICK_LEN +: BRICK_LEN] = GARBAGE_TYPE;
        end
        is_garb  = ctr < {2'b00, n_lat};
        // src_row is only used when ctr >= n, so the subtraction never wraps there
        src_row  = ctr - {2'b00, n_lat};
        row_fill = is_garb ? garb_fill : lat_board[TYPE_BITS + int'(src_row)*BOARD_W +: BOARD_W];
        row_type = is_garb ? garb_type : lat_board[int'(src_row)*ROW_T +: ROW_T];
        // latched row ctr is pushed off the top when ctr >= BOARD_H - n
        drop_hit = (ctr >= (5'(BOARD_H) - {2'b00, n_lat}))
                   && (|lat_board[TYPE_BITS + int'(ctr)*BOARD_W +: BOARD_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ctr       <= '0;
            n_lat     <= '0;
            h_lat     <= '0;
            lat_board <= EMPTY_BOARD;
            busy      <= 1'b0;
            done      <= 1'b0;
            topout    <= 1'b0;
            nxt_board <= EMPTY_BOARD;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lat_board <= cur_board;
                        n_lat     <= (int'(num_lines) > MAX_LINES) ? 3'(MAX_LINES) : num_lines;
                        h_lat     <= (int'(hole_col) >= BOARD_W) ? '0 : hole_col;
                        topout    <= 1'b0;
                        ctr       <= '0;
                        busy      <= 1'b1;
                        state     <= BUILD;
                    end
                end
                BUILD: begin
                    nxt_board[int'(ctr)*ROW_T +: ROW_T]                   <= row_type;
                    nxt_board[TYPE_BITS + int'(ctr)*BOARD_W +: BOARD_W]   <= row_fill;
                    if (drop_hit)
                        topout <= 1'b1;
                    if (ctr == LAST_ROW) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        ctr <= ctr + 5'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_garbage_insert.sv
// Directed/randomized bench for garbage_insert; expected boards come from an
// array-based model of row shifting and garbage insertion.
module tb_garbage_insert;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int BL = 3;
    localparam int BS = H * W * (BL + 1);
    localparam int TB = H * W * BL;
    localparam int MAXL = 4;
    localparam logic [2:0] GT = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    num_lines = '0;
    logic [3:0]    hole_col = '0;
    logic [BS-1:0] cur_board = '0;
    logic          busy, done, topout;
    logic [BS-1:0] nxt_board;

    int tests = 0;
    int fails = 0;

    garbage_insert #(.GARBAGE_TYPE(GT), .MAX_LINES(MAXL)) dut (
        .clk(clk), .rst(rst), .start(start), .num_lines(num_lines),
        .hole_col(hole_col), .cur_board(cur_board), .busy(busy), .done(done),
        .topout(topout), .nxt_board(nxt_board)
    );

    always #5 clk = ~clk;

    function automatic logic [BS-1:0] empty_board();
        logic [BS-1:0] b;
        b = '0;
        for (int i = 0; i < TB; i++) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [BS-1:0] rand_board();
        logic [BS-1:0] b;
        for (int i = 0; i < BS / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Reference: bottom n rows become garbage, row r of the result is old row r-n.
    function automatic logic [BS-1:0] model(input logic [BS-1:0] b, input int num,
                                            input int hole, output logic top);
        logic [BL-1:0] ty [H][W];
        logic          fl [H][W];
        logic [BS-1:0] o;
        int n, h;
        n = (num > MAXL) ? MAXL : num;
        h = (hole >= W) ? 0 : hole;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                ty[r][c] = b[(r*W + c)*BL +: BL];
                fl[r][c] = b[TB + r*W + c];
            end
        top = 1'b0;
        for (int r = H - n; r < H; r++)
            for (int c = 0; c < W; c++)
                if (fl[r][c]) top = 1'b1;
        o = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r < n) begin
                    o[TB + r*W + c]       = (c != h);
                    o[(r*W + c)*BL +: BL] = (c != h) ? GT : '1;
                end else begin
                    o[TB + r*W + c]       = fl[r-n][c];
                    o[(r*W + c)*BL +: BL] = ty[r-n][c];
                end
            end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [TB-1:0] obs, input logic [TB-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_board(input string tag, input logic [BS-1:0] exp);
        chk({tag, "_fill"}, TB'(nxt_board[BS-1:TB]), TB'(exp[BS-1:TB]));
        chk({tag, "_type"}, nxt_board[TB-1:0], exp[TB-1:0]);
    endtask

    // mode 0: plain op; 1: stray start before edge T+5; 2: reset at edge T+10
    task automatic run_op(input string tag, input logic [BS-1:0] b, input int num,
                          input int hole, input int mode);
        int first_done, n_done;
        logic [BS-1:0] snap, exp;
        logic etop;
        first_done = -1;
        n_done = 0;
        snap = '0;
        @(negedge clk);
        cur_board = b; num_lines = 3'(num); hole_col = 4'(hole); start = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
            if (k == 1) chk({tag, "_busy"}, TB'(busy), TB'(1'b1));
            if (mode == 1 && k == 4) begin start = 1'b1; cur_board = rand_board(); end
            if (mode == 1 && k == 5) start = 1'b0;
            if (mode == 2 && k == 9) rst = 1'b1;
            if (mode == 2 && k == 10) begin
                rst = 1'b0;
                chk({tag, "_rbusy"}, TB'(busy), TB'(1'b0));
                chk({tag, "_rdone"}, TB'(done), TB'(1'b0));
                chk({tag, "_rtop"}, TB'(topout), TB'(1'b0));
                chk_board({tag, "_rbrd"}, empty_board());
            end
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    snap = nxt_board;
                    chk({tag, "_busy_at_done"}, TB'(busy), TB'(1'b0));
                end
            end
        end
        if (mode == 2) begin
            chk({tag, "_ndone"}, TB'(n_done), TB'(0));
        end else begin
            chk({tag, "_lat"}, TB'(first_done), TB'(21));
            chk({tag, "_ndone"}, TB'(n_done), TB'(1));
            exp = model(b, num, hole, etop);
            chk_board(tag, exp);
            chk({tag, "_top"}, TB'(topout), TB'(etop));
            chk({tag, "_stable"}, TB'(nxt_board[BS-1:TB]), TB'(snap[BS-1:TB]));
        end
    endtask

    initial begin
        logic [BS-1:0] b, e;
        logic t;
        int first_done, second_done, n_done;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", TB'(busy), TB'(1'b0));
        chk("rst_done", TB'(done), TB'(1'b0));
        chk("rst_top", TB'(topout), TB'(1'b0));
        chk_board("rst_brd", empty_board());
        @(negedge clk);
        rst = 1'b0;

        run_op("empty_n2", empty_board(), 2, 3, 0);
        chk("r0_fill_const", TB'(nxt_board[TB +: W]), TB'(10'b1111110111));
        chk("r1_fill_const", TB'(nxt_board[TB + W +: W]), TB'(10'b1111110111));
        chk("r0_type_c0", TB'(nxt_board[0 +: BL]), TB'(3'd7));

        b = empty_board();
        b[TB + 19*W] = 1'b1;
        b[19*W*BL +: BL] = 3'd2;
        run_op("top19_n1", b, 1, 5, 0);
        chk("top19_const", TB'(topout), TB'(1'b1));

        b = rand_board();
        run_op("n0", b, 0, 4, 0);
        chk_board("n0_ident", b);
        chk("n0_top", TB'(topout), TB'(1'b0));

        b = rand_board();
        run_op("clamp", b, 7, 12, 0);
        e = model(b, 4, 0, t);
        chk_board("clamp_as_n4h0", e);

        for (int i = 0; i < 5; i++)
            run_op($sformatf("rnd%0d", i), rand_board(), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 15)), 0);

        run_op("stray", rand_board(), 3, 6, 1);
        run_op("reset", rand_board(), 2, 1, 2);
        run_op("after_rst", rand_board(), 2, 8, 0);

        // start held high: second accept lands in the cycle after DONE
        b = rand_board();
        first_done = -1; second_done = -1; n_done = 0;
        @(negedge clk);
        cur_board = b; num_lines = 3'd1; hole_col = 4'd9; start = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 22) start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        chk("held_first", TB'(first_done), TB'(21));
        chk("held_second", TB'(second_done), TB'(43));
        chk("held_ndone", TB'(n_done), TB'(2));
        chk_board("held_brd", model(b, 1, 9, t));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
